// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and recovered-timing outputs of the VGA sync monitor.
// The master side drives the sync signals; the slave side is the monitor.
interface vga_sync_monitor_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        de_in;
  logic        locked;
  logic [10:0] col_addr;
  logic [10:0] row_addr;
  logic        active_out;
  logic        frame_start;
  logic [10:0] frame_lines;
  logic        line_err;
  logic        frame_err;
  logic        de_err;

  modport master (
    output hsync_in, vsync_in, de_in,
    input  locked, col_addr, row_addr, active_out, frame_start,
           frame_lines, line_err, frame_err, de_err
  );

  modport slave (
    input  hsync_in, vsync_in, de_in,
    output locked, col_addr, row_addr, active_out, frame_start,
           frame_lines, line_err, frame_err, de_err
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from hsync/vsync,
// locks to a stable line/frame structure and pulses on timing errors.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_ACT_START = 32,
  parameter int V_ACT       = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_sync_monitor_if.slave mon
);

  localparam logic [11:0] H_TOTAL_W   = 12'(H_TOTAL);
  localparam logic [11:0] H_TIMEOUT_W = 12'(2 * H_TOTAL);
  localparam logic [11:0] H_START_W   = 12'(H_ACT_START);
  localparam logic [11:0] H_END_W     = 12'(H_ACT_START + H_ACT);
  localparam logic [10:0] V_START_W   = 11'(V_ACT_START);
  localparam logic [10:0] V_END_W     = 11'(V_ACT_START + V_ACT);

  typedef enum logic [1:0] {SEARCH, MEASURE, CONFIRM, LOCKED} state_t;

  state_t      state_q;
  logic        hs_q;
  logic        vs_q;
  logic        h_seen_q;
  logic [11:0] h_pos_q;
  logic [11:0] h_pos_d;
  logic [10:0] v_pos_q;
  logic [10:0] v_pos_d;
  logic [10:0] lc_q;
  logic [10:0] lc_d;
  logic [10:0] ref_q;
  logic        locked_q;
  logic        active_q;
  logic        frame_start_q;
  logic        line_err_q;
  logic        frame_err_q;
  logic        de_err_q;
  logic [10:0] col_q;
  logic [10:0] row_q;
  logic [10:0] frame_lines_q;

  logic        hs_fall;
  logic        vs_fall;
  logic        exp_act;
  logic        line_err_c;
  logic [11:0] h_now;
  logic [10:0] v_now;
  logic [10:0] count;

  always_comb begin
    hs_fall = hs_q & ~mon.hsync_in;
    vs_fall = vs_q & ~mon.vsync_in;
    h_now   = hs_fall ? 12'd0 : h_pos_q;
    h_pos_d = (h_now == 12'hFFF) ? h_now : h_now + 12'd1;
    if (vs_fall)
      v_now = 11'd0;
    else if (hs_fall)
      v_now = (v_pos_q == 11'h7FF) ? v_pos_q : v_pos_q + 11'd1;
    else
      v_now = v_pos_q;
    v_pos_d = v_now;
    // count includes an hsync fall that coincides with the vsync fall
    count   = lc_q + {10'd0, hs_fall};
    if (vs_fall)
      lc_d = 11'd0;
    else
      lc_d = (lc_q == 11'h7FF) ? lc_q : count;
    exp_act = (h_now >= H_START_W) && (h_now < H_END_W) &&
              (v_now >= V_START_W) && (v_now < V_END_W);
    line_err_c = (hs_fall & h_seen_q & (h_pos_q != H_TOTAL_W)) |
                 (~hs_fall & (h_pos_q == H_TIMEOUT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_seen_q      <= 1'b0;
      h_pos_q       <= 12'd0;
      v_pos_q       <= 11'd0;
      lc_q          <= 11'd0;
      ref_q         <= 11'd0;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      col_q         <= 11'd0;
      row_q         <= 11'd0;
      frame_start_q <= 1'b0;
      frame_lines_q <= 11'd0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      de_err_q      <= 1'b0;
    end else begin
      hs_q          <= mon.hsync_in;
      vs_q          <= mon.vsync_in;
      h_pos_q       <= h_pos_d;
      v_pos_q       <= v_pos_d;
      lc_q          <= lc_d;
      frame_start_q <= vs_fall;
      line_err_q    <= line_err_c;
      de_err_q      <= locked_q & (mon.de_in != exp_act);
      locked_q      <= (state_q == LOCKED);
      frame_err_q   <= 1'b0;
      if (vs_fall)
        frame_lines_q <= count;

      if (locked_q && exp_act) begin
        active_q <= 1'b1;
        col_q    <= 11'(h_now - H_START_W);
        row_q    <= v_now - V_START_W;
      end else begin
        active_q <= 1'b0;
        col_q    <= 11'd0;
        row_q    <= 11'd0;
      end

      // A line error overrides whatever the vsync fall would have done
      if (line_err_c) begin
        state_q  <= SEARCH;
        h_seen_q <= 1'b0;
        ref_q    <= 11'd0;
      end else begin
        if (hs_fall)
          h_seen_q <= 1'b1;
        case (state_q)
          SEARCH: begin
            ref_q <= 11'd0;
            if (vs_fall)
              state_q <= MEASURE;
          end
          MEASURE: begin
            if (vs_fall) begin
              ref_q   <= count;
              state_q <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (vs_fall) begin
              if (count == ref_q)
                state_q <= LOCKED;
              else
                ref_q <= count;
            end
          end
          LOCKED: begin
            if (vs_fall && (count != ref_q)) begin
              frame_err_q <= 1'b1;
              ref_q       <= count;
              state_q     <= CONFIRM;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign mon.locked      = locked_q;
  assign mon.active_out  = active_q;
  assign mon.col_addr    = col_q;
  assign mon.row_addr    = row_q;
  assign mon.frame_start = frame_start_q;
  assign mon.frame_lines = frame_lines_q;
  assign mon.line_err    = line_err_q;
  assign mon.frame_err   = frame_err_q;
  assign mon.de_err      = de_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a scaled-down raster so that several
// frames fit in a short run; expectations come from a frame-history model.
module tb_vga_sync_monitor;
  localparam int HT    = 40;
  localparam int HAS   = 8;
  localparam int HA    = 28;
  localparam int VAS   = 2;
  localparam int VA    = 20;
  localparam int VT    = 24;
  localparam int HSW   = 4;
  localparam int VSW   = 2;
  localparam int FRAME = HT * VT;

  logic clk;
  logic rst_n;
  vga_sync_monitor_if bus();

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT(HA), .V_ACT_START(VAS), .V_ACT(VA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mon(bus)
  );

  int checks;
  int errors;

  // raster generator state
  int g_h, g_v, g_len, g_lines, g_long, short_v, hold_lo, hold_hi, kill_h, kill_v;
  bit hold_en, kill_en;
  int drv_h, drv_v;

  // reference model state
  int m_h, m_v, m_lc;
  bit m_hs_prev, m_vs_prev, m_seen, m_st_lock, m_lock_out;
  int m_hist[$];
  logic        e_locked, e_active, e_frame_start, e_line_err, e_frame_err, e_de_err;
  logic [10:0] e_col, e_row, e_frame_lines;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  task automatic gen_reset();
    g_h = 0; g_v = 0; g_len = HT; g_lines = VT; g_long = 0;
    short_v = -1; hold_en = 0; kill_en = 0;
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_lc = 0;
    m_hs_prev = 1; m_vs_prev = 1; m_seen = 0; m_st_lock = 0; m_lock_out = 0;
    m_hist.delete();
    e_locked = 0; e_active = 0; e_frame_start = 0; e_line_err = 0;
    e_frame_err = 0; e_de_err = 0; e_col = 0; e_row = 0; e_frame_lines = 0;
  endtask

  // Predicts the outputs visible after the coming clock edge. Locking is
  // judged from the list of frame line counts seen since the last line error:
  // the first count is discarded, then two equal consecutive counts lock.
  task automatic model_step();
    bit hf, vf, err, win;
    int h_now, v_now, cnt;
    hf = m_hs_prev && !bus.hsync_in;
    vf = m_vs_prev && !bus.vsync_in;
    m_hs_prev = bus.hsync_in;
    m_vs_prev = bus.vsync_in;
    h_now = hf ? 0 : m_h;
    v_now = vf ? 0 : (hf ? m_v + 1 : m_v);
    if (v_now > 2047) v_now = 2047;
    win = (h_now >= HAS) && (h_now < HAS + HA) && (v_now >= VAS) && (v_now < VAS + VA);
    err = (hf && m_seen && m_h != HT) || (!hf && m_h == 2 * HT);
    cnt = m_lc + (hf ? 1 : 0);
    e_line_err    = err;
    e_frame_start = vf;
    e_active      = m_lock_out && win;
    e_col         = e_active ? 11'(h_now - HAS) : 11'd0;
    e_row         = e_active ? 11'(v_now - VAS) : 11'd0;
    e_de_err      = m_lock_out && (bus.de_in != win);
    e_frame_err   = !err && vf && m_st_lock && (cnt != m_hist[$]);
    if (vf) e_frame_lines = 11'(cnt);
    e_locked   = m_st_lock;
    m_lock_out = m_st_lock;
    if (err) begin
      m_hist.delete();
      m_st_lock = 0;
      m_seen = 0;
    end else begin
      if (hf) m_seen = 1;
      if (vf) begin
        m_hist.push_back(cnt);
        m_st_lock = (m_hist.size() >= 3) && (m_hist[$] == m_hist[$-1]);
      end
    end
    m_lc = vf ? 0 : (cnt > 2047 ? 2047 : cnt);
    m_h  = (h_now + 1 > 4095) ? 4095 : h_now + 1;
    m_v  = v_now;
  endtask

  // Drive one raster sample, step the model, and advance past the clock edge.
  task automatic tick();
    drv_h = g_h;
    drv_v = g_v;
    bus.hsync_in = (hold_en && g_v >= hold_lo && g_v <= hold_hi) ? 1'b1 : (g_h >= HSW);
    bus.vsync_in = (g_v >= VSW);
    bus.de_in = (g_h >= HAS && g_h < HAS + HA && g_v >= VAS && g_v < VAS + VA) &&
                !(kill_en && g_h == kill_h && g_v == kill_v);
    if (kill_en && g_h == kill_h && g_v == kill_v) kill_en = 0;
    model_step();
    @(posedge clk);
    #1;
    g_h++;
    if (g_h >= g_len) begin
      g_h = 0;
      g_v++;
      if (g_v >= g_lines) begin
        g_v = 0;
        if (g_long > 0) begin
          g_lines = VT + 1;
          g_long--;
        end else begin
          g_lines = VT;
        end
      end
      if (hold_en && g_v > hold_hi) hold_en = 0;
      if (g_v == short_v) begin
        g_len = HT - 1;
        short_v = -1;
      end else begin
        g_len = HT;
      end
    end
  endtask

  task automatic align();
    for (int i = 0; i < 2 * FRAME && !(g_h == 0 && g_v == 0); i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.de_in = 1'b0;
    gen_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL reset_locked got %0d want 0", bus.locked);
    end
    checks++;
    if ({bus.col_addr, bus.row_addr, bus.frame_lines} !== 33'd0) begin
      errors++; $display("FAIL reset_counts got col %0d row %0d lines %0d want 0", bus.col_addr, bus.row_addr, bus.frame_lines);
    end
    checks++;
    if ({bus.active_out, bus.frame_start, bus.line_err, bus.frame_err, bus.de_err} !== 5'd0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {bus.active_out, bus.frame_start, bus.line_err, bus.frame_err, bus.de_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int fs_n = 0;
    int fs3 = -1;
    int lk = -1;
    for (int c = 0; c < 2 * FRAME + 10; c++) begin
      tick();
      checks++;
      if (bus.locked !== e_locked) begin
        errors++; $display("FAIL lock_locked cyc %0d got %0d want %0d", c, bus.locked, e_locked);
      end
      checks++;
      if ({bus.frame_start, bus.line_err, bus.frame_err} !== {e_frame_start, e_line_err, e_frame_err}) begin
        errors++; $display("FAIL lock_pulses cyc %0d got %b want %b", c, {bus.frame_start, bus.line_err, bus.frame_err}, {e_frame_start, e_line_err, e_frame_err});
      end
      checks++;
      if (bus.frame_lines !== e_frame_lines) begin
        errors++; $display("FAIL lock_frame_lines cyc %0d got %0d want %0d", c, bus.frame_lines, e_frame_lines);
      end
      if (bus.frame_start === 1'b1) begin
        fs_n++;
        if (fs_n == 3) fs3 = c;
      end
      if (bus.locked === 1'b1 && lk < 0) lk = c;
    end
    checks++;
    if (fs3 != 2 * FRAME || lk != 2 * FRAME + 1) begin
      errors++; $display("FAIL lock_latency got fs3 %0d lock %0d want %0d %0d", fs3, lk, 2 * FRAME, 2 * FRAME + 1);
    end
    checks++;
    if (bus.frame_lines !== 11'(VT)) begin
      errors++; $display("FAIL lock_lines_final got %0d want %0d", bus.frame_lines, VT);
    end
  endtask

  task automatic test_addr();
    align();
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if ({bus.active_out, bus.col_addr, bus.row_addr} !== {e_active, e_col, e_row}) begin
        errors++; $display("FAIL addr_window h %0d v %0d got %0d/%0d/%0d want %0d/%0d/%0d", drv_h, drv_v, bus.active_out, bus.col_addr, bus.row_addr, e_active, e_col, e_row);
      end
      checks++;
      if (bus.de_err !== e_de_err) begin
        errors++; $display("FAIL addr_de_err h %0d v %0d got %0d want %0d", drv_h, drv_v, bus.de_err, e_de_err);
      end
      if (drv_h == HAS && drv_v == VAS) begin
        checks++;
        if ({bus.active_out, bus.col_addr, bus.row_addr} !== {1'b1, 11'd0, 11'd0}) begin
          errors++; $display("FAIL addr_first got %0d/%0d/%0d want 1/0/0", bus.active_out, bus.col_addr, bus.row_addr);
        end
      end
      if (drv_h == HAS + HA - 1 && drv_v == VAS + VA - 1) begin
        checks++;
        if ({bus.active_out, bus.col_addr, bus.row_addr} !== {1'b1, 11'(HA - 1), 11'(VA - 1)}) begin
          errors++; $display("FAIL addr_last got %0d/%0d/%0d want 1/%0d/%0d", bus.active_out, bus.col_addr, bus.row_addr, HA - 1, VA - 1);
        end
      end
      if (drv_h == HAS + HA && drv_v == VAS) begin
        checks++;
        if ({bus.active_out, bus.col_addr, bus.row_addr} !== {1'b0, 11'd0, 11'd0}) begin
          errors++; $display("FAIL addr_after got %0d/%0d/%0d want 0/0/0", bus.active_out, bus.col_addr, bus.row_addr);
        end
      end
    end
  endtask

  task automatic test_de_drop();
    int pulses = 0;
    align();
    kill_h = $urandom_range(HAS + HA - 1, HAS);
    kill_v = $urandom_range(VAS + VA - 1, VAS);
    kill_en = 1;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if ({bus.de_err, bus.locked} !== {e_de_err, e_locked}) begin
        errors++; $display("FAIL de_drop h %0d v %0d got de_err %0d locked %0d want %0d %0d", drv_h, drv_v, bus.de_err, bus.locked, e_de_err, e_locked);
      end
      if (bus.de_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.locked !== 1'b1) begin
      errors++; $display("FAIL de_drop_count got pulses %0d locked %0d want 1 1", pulses, bus.locked);
    end
  endtask

  task automatic test_short_line();
    int sv, ec = -1, le_n = 0, fs_n = 0, fs3 = -1, lk = -1;
    align();
    sv = $urandom_range(VT - 2, 3);
    short_v = sv;
    for (int c = 0; c < 5 * FRAME; c++) begin
      tick();
      checks++;
      if ({bus.line_err, bus.frame_err, bus.locked} !== {e_line_err, e_frame_err, e_locked}) begin
        errors++; $display("FAIL short_flags cyc %0d got %b want %b", c, {bus.line_err, bus.frame_err, bus.locked}, {e_line_err, e_frame_err, e_locked});
      end
      if (bus.line_err === 1'b1) begin
        le_n++;
        if (ec < 0) begin
          ec = c;
          checks++;
          if (drv_v != sv + 1 || drv_h != 0) begin
            errors++; $display("FAIL short_err_pos got v %0d h %0d want v %0d h 0", drv_v, drv_h, sv + 1);
          end
        end
      end
      if (ec >= 0 && c == ec + 1) begin
        checks++;
        if (bus.locked !== 1'b0) begin
          errors++; $display("FAIL short_unlock got %0d want 0", bus.locked);
        end
      end
      if (ec >= 0 && c > ec && bus.frame_start === 1'b1) begin
        fs_n++;
        if (fs_n == 3) fs3 = c;
      end
      if (ec >= 0 && c > ec + 1 && bus.locked === 1'b1 && lk < 0) lk = c;
    end
    checks++;
    if (le_n != 1 || fs3 < 0 || lk != fs3 + 1) begin
      errors++; $display("FAIL short_relock got errs %0d fs3 %0d lock %0d want 1 and lock one after fs3", le_n, fs3, lk);
    end
  endtask

  task automatic test_hsync_timeout();
    int ln, ec = -1, le_n = 0, lk = -1;
    align();
    ln = $urandom_range(VT - 6, 3);
    hold_lo = ln;
    hold_hi = ln + 2;
    hold_en = 1;
    for (int c = 0; c < 5 * FRAME; c++) begin
      tick();
      checks++;
      if ({bus.line_err, bus.locked, bus.active_out} !== {e_line_err, e_locked, e_active}) begin
        errors++; $display("FAIL timeout_flags cyc %0d got %b want %b", c, {bus.line_err, bus.locked, bus.active_out}, {e_line_err, e_locked, e_active});
      end
      if (bus.line_err === 1'b1) begin
        le_n++;
        if (ec < 0) begin
          ec = c;
          checks++;
          if (drv_v != ln + 1 || drv_h != 0) begin
            errors++; $display("FAIL timeout_pos got v %0d h %0d want v %0d h 0", drv_v, drv_h, ln + 1);
          end
        end
      end
      if (ec >= 0 && c == ec + 1) begin
        checks++;
        if ({bus.locked, bus.active_out, bus.col_addr, bus.row_addr} !== 24'd0) begin
          errors++; $display("FAIL timeout_outputs got %0d/%0d/%0d/%0d want 0/0/0/0", bus.locked, bus.active_out, bus.col_addr, bus.row_addr);
        end
      end
      if (ec >= 0 && c > ec + 1 && bus.locked === 1'b1 && lk < 0) lk = c;
    end
    checks++;
    if (le_n != 1 || lk < 0) begin
      errors++; $display("FAIL timeout_relock got errs %0d lock_cyc %0d want 1 and relock", le_n, lk);
    end
  endtask

  task automatic test_frame_len();
    int fs_n = 0, fe_n = 0;
    align();
    g_long = 2;
    for (int c = 0; c < 5 * FRAME + 100; c++) begin
      tick();
      checks++;
      if ({bus.frame_err, bus.locked, bus.frame_lines} !== {e_frame_err, e_locked, e_frame_lines}) begin
        errors++; $display("FAIL frame_flags cyc %0d got fe %0d lk %0d lines %0d want %0d %0d %0d", c, bus.frame_err, bus.locked, bus.frame_lines, e_frame_err, e_locked, e_frame_lines);
      end
      if (bus.frame_err === 1'b1) fe_n++;
      if (fs_n == 3 && bus.frame_start === 1'b0 && bus.locked !== 1'b0 && bus.frame_lines == 11'(VT + 1)) begin
        checks++;
        errors++; $display("FAIL frame_unlock got locked %0d want 0", bus.locked);
      end
      if (bus.frame_start === 1'b1) begin
        fs_n++;
        if (fs_n == 3) begin
          checks++;
          if (bus.frame_err !== 1'b1 || bus.frame_lines !== 11'(VT + 1)) begin
            errors++; $display("FAIL frame_err_long got fe %0d lines %0d want 1 %0d", bus.frame_err, bus.frame_lines, VT + 1);
          end
        end
        if (fs_n == 4) begin
          tick();
          checks++;
          if (bus.locked !== 1'b1 || bus.frame_lines !== 11'(VT + 1)) begin
            errors++; $display("FAIL frame_relock_long got lk %0d lines %0d want 1 %0d", bus.locked, bus.frame_lines, VT + 1);
          end
        end
      end
    end
    checks++;
    if (fe_n != 2 || bus.locked !== 1'b1 || bus.frame_lines !== 11'(VT)) begin
      errors++; $display("FAIL frame_final got fe %0d lk %0d lines %0d want 2 1 %0d", fe_n, bus.locked, bus.frame_lines, VT);
    end
  endtask

  task automatic test_reset_mid();
    int n, lk = -1;
    align();
    n = $urandom_range(5 * HT, HAS + 5);
    for (int c = 0; c < n; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL mid_reset_locked got %0d want 0", bus.locked);
    end
    checks++;
    if ({bus.col_addr, bus.row_addr, bus.frame_lines} !== 33'd0) begin
      errors++; $display("FAIL mid_reset_counts got col %0d row %0d lines %0d want 0", bus.col_addr, bus.row_addr, bus.frame_lines);
    end
    checks++;
    if ({bus.active_out, bus.frame_start, bus.line_err, bus.frame_err, bus.de_err} !== 5'd0) begin
      errors++; $display("FAIL mid_reset_flags got %b want 00000", {bus.active_out, bus.frame_start, bus.line_err, bus.frame_err, bus.de_err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gen_reset();
    model_reset();
    for (int c = 0; c < 2 * FRAME + 10; c++) begin
      tick();
      checks++;
      if ({bus.locked, bus.frame_start} !== {e_locked, e_frame_start}) begin
        errors++; $display("FAIL mid_relock cyc %0d got %b want %b", c, {bus.locked, bus.frame_start}, {e_locked, e_frame_start});
      end
      if (bus.locked === 1'b1 && lk < 0) lk = c;
    end
    checks++;
    if (lk != 2 * FRAME + 1) begin
      errors++; $display("FAIL mid_relock_latency got %0d want %0d", lk, 2 * FRAME + 1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lock();
    test_addr();
    test_de_drop();
    test_short_line();
    test_hsync_timeout();
    test_frame_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the 640x480 VGA sync generator; consumes hsync/vsync/data-enable and recovers column/row pixel addresses.
- Measures line length and lines per frame, locks to stable timing, and flags line, frame and data-enable timing errors.
- Sits on a loopback/debug path beside the display output, and feeds the self-check logic and the on-board error LEDs.

Parameters:
- H_TOTAL, 800, expected clocks per line (hsync fall to hsync fall)
- H_ACT_START, 144, line position (0 = first hsync-low sample) of first active pixel
- H_ACT, 640, active pixels per line
- V_ACT_START, 32, line index (0 = line of vsync fall) of first active row
- V_ACT, 480, active rows per frame

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hsync_in  in  1  horizontal sync, active low, synchronous to clk
- vsync_in  in  1  vertical sync, active low, synchronous to clk
- de_in  in  1  data enable from the generator
- locked  out  1  high while timing is locked
- col_addr  out  11  recovered column, 0..H_ACT-1 when active_out, else 0
- row_addr  out  11  recovered row, 0..V_ACT-1 when active_out, else 0
- active_out  out  1  recovered active window, gated by locked
- frame_start  out  1  one-cycle pulse per vsync falling edge
- frame_lines  out  11  line count of the last completed frame
- line_err  out  1  one-cycle pulse: bad line length or hsync timeout
- frame_err  out  1  one-cycle pulse: frame line count changed while locked
- de_err  out  1  one-cycle pulse: de_in differs from expected window while locked

Behaviour:
- Reset: all outputs 0, state SEARCH, internal counters 0, hs_d/vs_d = 1.
- Edge detect: hs_fall = hs_d & ~hsync_in; vs_fall = vs_d & ~vsync_in. hs_d and vs_d register the inputs every cycle.
- Horizontal position: h_now = hs_fall ? 0 : h_pos; h_pos <= h_now+1; 12-bit, saturates at 4095.
- Vertical position: v_now = vs_fall ? 0 : (hs_fall ? v_pos+1 : v_pos); v_pos <= v_now; 11-bit, saturates at 2047.
- If vs_fall and hs_fall occur in the same cycle, v_now = 0.
- Outputs are registered with 1-cycle latency from the input sample. exp_act = H_ACT_START<=h_now<H_ACT_START+H_ACT and V_ACT_START<=v_now<V_ACT_START+V_ACT.
- When locked & exp_act: active_out<=1, col_addr<=h_now-H_ACT_START, row_addr<=v_now-V_ACT_START. Otherwise all three <=0.
- de_err <= locked & (de_in != exp_act).
- frame_start <= vs_fall.
- Line check: h_seen is set on the first hs_fall after entering SEARCH.
  - Bad length: on hs_fall with h_seen and h_pos != H_TOTAL.
  - Timeout: h_pos == 2*H_TOTAL without hs_fall, pulsed once per timeout.
  - Either condition sets line_err=1 for one cycle; state -> SEARCH next cycle from any state.
- Frame line counter lc: reset to 0 on vs_fall, +1 on each hs_fall. On vs_fall, frame_lines <= lc (or lc+1 if hs_fall in the same cycle).
- FSM:
  - SEARCH: clear h_seen and ref. On vs_fall -> MEASURE.
  - MEASURE: on vs_fall, ref <= count -> CONFIRM.
  - CONFIRM: on vs_fall, if count==ref -> LOCKED; else ref <= count, stay CONFIRM.
  - LOCKED: locked=1. On vs_fall with count != ref -> frame_err pulse, ref <= count, -> CONFIRM.
  - Line error in any state -> SEARCH, with priority over vs_fall handling in the same cycle.
- locked is a registered decode of state==LOCKED; it drops in the cycle after the error pulse.
- Reset mid-frame: immediate return to reset values; relock requires a full SEARCH/MEASURE/CONFIRM sequence, i.e. the third vsync fall after reset.

Test Plan:
- Ideal 800x524 timing, hsync low 96 clk, vsync low 2 lines, de at h 144..783 / v 32..511 -> locked rises 1 clk after the 3rd vsync fall; frame_lines=524; no error pulses.
- Locked, sample at h_now=144, v_now=32 -> next cycle col_addr=0, row_addr=0, active_out=1. At h_now=783, v_now=511 -> col_addr=639, row_addr=479. At h_now=784 -> col_addr=0, active_out=0.
- Locked, one line shortened to 799 clk -> line_err pulse at that hsync fall; locked=0 next cycle; relock after 3 further vsync falls.
- Locked, hsync held high -> line_err at h_pos=1600; state SEARCH; outputs 0.
- Locked, one frame of 525 lines -> frame_err at its vsync fall, locked=0; a second 525-line frame -> locked=1, frame_lines=525.
- Locked, de_in forced low for one active pixel -> single de_err pulse; locked stays 1. Assert rst_n mid-line -> all outputs 0 immediately.
